vga_sprite_render: RTL and testbench

Pixel-generation stage directly downstream of the VGA timing generator in the 1280x1024 @ 108 MHz display path. It consumes the raw pixel coordinates, valid and sync signals, and draws a single solid rectangular sprite over a background with a one-pixel screen border. It outputs 4:4:4 RGB with hsync/vsync delayed to stay pixel-aligned. Sprite position updates arrive from game logic through a valid/ready handshake and take effect only at a frame boundary, so no frame ever shows a tear.

---
 rtl/vga_sprite_render.sv | 153 +++++++++++++++
 tb/tb_vga_sprite_render.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_render.sv
// Pixel stage after the VGA timing generator: border, one solid sprite, background.
// Two-cycle pixel pipeline; sprite position updates are double-buffered and committed in vertical blanking.
module vga_sprite_render #(
  parameter int          SPR_W        = 32,
  parameter int          SPR_H        = 32,
  parameter int          H_VIS        = 1280,
  parameter int          V_VIS        = 1024,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] SPR_COLOR    = 12'hF00,
  parameter logic [11:0] BORDER_COLOR = 12'hFFF,
  parameter logic        SYNC_IDLE    = 1'b0
) (
  input  logic        vgaClk,
  input  logic        rst_n,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  input  logic        valid_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        pos_valid,
  output logic        pos_ready,
  input  logic [11:0] pos_x,
  input  logic [11:0] pos_y,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  localparam logic [12:0] MAX_X   = 13'(H_VIS - SPR_W);
  localparam logic [12:0] MAX_Y   = 13'(V_VIS - SPR_H);
  localparam logic [11:0] RST_X   = 12'((H_VIS - SPR_W) / 2);
  localparam logic [11:0] RST_Y   = 12'((V_VIS - SPR_H) / 2);
  localparam logic [12:0] SPR_W13 = 13'(SPR_W);
  localparam logic [12:0] SPR_H13 = 13'(SPR_H);
  localparam logic [11:0] LAST_X  = 12'(H_VIS - 1);
  localparam logic [11:0] LAST_Y  = 12'(V_VIS - 1);
  localparam logic [11:0] COMMIT_Y = 12'(V_VIS);

  logic        pending_full_reg;
  logic [11:0] pend_x_reg, pend_y_reg;
  logic [11:0] act_x_reg, act_y_reg;
  logic        frame_tick_reg;
  logic [15:0] frame_count_reg;
  logic [11:0] pend_x_next, pend_y_next;
  logic        accept, commit;

  logic        valid1_reg, in_spr1_reg, in_border1_reg;
  logic        in_spr_next, in_border_next;
  logic [11:0] rgb_reg, rgb_next;
  logic [1:0]  sync_in, sync_out;

  assign pos_ready = !pending_full_reg;
  assign accept    = pos_valid && !pending_full_reg;
  // First blanking line start: the only point where the active position may change.
  assign commit    = (x_in == 12'd0) && (y_in == COMMIT_Y) && pending_full_reg;

  always_comb begin
    pend_x_next = pos_x;
    pend_y_next = pos_y;
    if ({1'b0, pos_x} > MAX_X) pend_x_next = 12'(MAX_X);
    if ({1'b0, pos_y} > MAX_Y) pend_y_next = 12'(MAX_Y);
  end

  always_ff @(posedge vgaClk or negedge rst_n) begin
    if (!rst_n) begin
      pending_full_reg <= 1'b0;
      pend_x_reg       <= 12'd0;
      pend_y_reg       <= 12'd0;
      act_x_reg        <= RST_X;
      act_y_reg        <= RST_Y;
      frame_tick_reg   <= 1'b0;
      frame_count_reg  <= 16'd0;
    end else begin
      frame_tick_reg <= commit;
      if (commit) begin
        act_x_reg        <= pend_x_reg;
        act_y_reg        <= pend_y_reg;
        pending_full_reg <= 1'b0;
        frame_count_reg  <= frame_count_reg + 16'd1;
      end else if (accept) begin
        pend_x_reg       <= pend_x_next;
        pend_y_reg       <= pend_y_next;
        pending_full_reg <= 1'b1;
      end
    end
  end

  assign frame_tick  = frame_tick_reg;
  assign frame_count = frame_count_reg;

  // 13-bit compares so ax+SPR_W at the right/bottom edge cannot wrap.
  always_comb begin
    in_spr_next = ({1'b0, x_in} >= {1'b0, act_x_reg}) &&
                  ({1'b0, x_in} <  ({1'b0, act_x_reg} + SPR_W13)) &&
                  ({1'b0, y_in} >= {1'b0, act_y_reg}) &&
                  ({1'b0, y_in} <  ({1'b0, act_y_reg} + SPR_H13));
    in_border_next = valid_in && ((x_in == 12'd0) || (x_in == LAST_X) ||
                                  (y_in == 12'd0) || (y_in == LAST_Y));
  end

  always_ff @(posedge vgaClk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_reg     <= 1'b0;
      in_spr1_reg    <= 1'b0;
      in_border1_reg <= 1'b0;
    end else begin
      valid1_reg     <= valid_in;
      in_spr1_reg    <= in_spr_next;
      in_border1_reg <= in_border_next;
    end
  end

  always_comb begin
    rgb_next = BG_COLOR;
    if (!valid1_reg)         rgb_next = 12'h000;
    else if (in_border1_reg) rgb_next = BORDER_COLOR;
    else if (in_spr1_reg)    rgb_next = SPR_COLOR;
  end

  always_ff @(posedge vgaClk or negedge rst_n) begin
    if (!rst_n) rgb_reg <= 12'h000;
    else        rgb_reg <= rgb_next;
  end

  assign vga_r = rgb_reg[11:8];
  assign vga_g = rgb_reg[7:4];
  assign vga_b = rgb_reg[3:0];

  assign sync_in = {vsync_in, hsync_in};

  // Each sync gets its own two-flop delay so it stays aligned with RGB.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic d1_reg, d2_reg;
    always_ff @(posedge vgaClk or negedge rst_n) begin
      if (!rst_n) begin
        d1_reg <= SYNC_IDLE;
        d2_reg <= SYNC_IDLE;
      end else begin
        d1_reg <= sync_in[gi];
        d2_reg <= d1_reg;
      end
    end
    assign sync_out[gi] = d2_reg;
  end

  assign hsync_out = sync_out[0];
  assign vsync_out = sync_out[1];

endmodule

// File: tb/tb_vga_sprite_render.sv
// Scoreboard bench for vga_sprite_render: point probes with a reference colour model,
// position handshake/commit model, async reset and frame counter wrap.
module tb_vga_sprite_render;

  logic        vgaClk = 1'b0;
  logic        rst_n  = 1'b0;
  logic [11:0] x_in = '0, y_in = '0;
  logic        valid_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic        pos_valid = 1'b0;
  logic        pos_ready;
  logic [11:0] pos_x = '0, pos_y = '0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync_out, vsync_out, frame_tick;
  logic [15:0] frame_count;

  always #5 vgaClk = ~vgaClk;

  vga_sprite_render dut (
    .vgaClk(vgaClk), .rst_n(rst_n),
    .x_in(x_in), .y_in(y_in), .valid_in(valid_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pos_valid(pos_valid), .pos_ready(pos_ready),
    .pos_x(pos_x), .pos_y(pos_y),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .frame_tick(frame_tick), .frame_count(frame_count)
  );

  typedef struct {
    int         x;
    int         y;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_ax, m_ay, m_px, m_py, m_cnt;
  bit m_full, m_tick, m_accept;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_color(int x, int y, bit v, int ax, int ay);
    if (!v) return 12'h000;
    if (x == 0 || x == 1279 || y == 0 || y == 1023) return 12'hFFF;
    if (x >= ax && x < ax + 32 && y >= ay && y < ay + 32) return 12'hF00;
    return 12'h000;
  endfunction

  task automatic model_reset();
    m_ax = 624; m_ay = 496; m_px = 0; m_py = 0; m_cnt = 0;
    m_full = 1'b0; m_tick = 1'b0; m_accept = 1'b0;
    exp_q.delete();
  endtask

  // One pixel transaction: sample outputs due now, then drive the next input.
  task automatic step(input int x, input int y, input bit v, input bit pv, input int px, input int py);
    exp_t e;
    bit hs, vs;
    @(negedge vgaClk);
    check_val("pos_ready", 32'(pos_ready), 32'(!m_full));
    check_val("frame_tick", 32'(frame_tick), 32'(m_tick));
    check_val("frame_count", 32'(frame_count), 32'(m_cnt));
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check_val($sformatf("rgb@%0d,%0d", e.x, e.y), 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
      check_val("hsync", 32'(hsync_out), 32'(e.hs));
      check_val("vsync", 32'(vsync_out), 32'(e.vs));
    end
    hs = 1'($urandom_range(1));
    vs = 1'($urandom_range(1));
    x_in = 12'(x); y_in = 12'(y); valid_in = v;
    hsync_in = hs; vsync_in = vs;
    pos_valid = pv; pos_x = 12'(px); pos_y = 12'(py);
    e.x = x; e.y = y; e.hs = hs; e.vs = vs;
    e.rgb = exp_color(x, y, v, m_ax, m_ay);
    exp_q.push_back(e);
    $display("px x=%0d y=%0d v=%0d pv=%0d pos=(%0d,%0d) exp_rgb=%03h", x, y, v, pv, px, py, e.rgb);
    m_tick   = (x == 0 && y == 1024 && m_full);
    m_accept = pv && !m_full;
    if (m_tick) begin
      m_ax = m_px; m_ay = m_py; m_full = 1'b0;
      m_cnt = (m_cnt + 1) & 16'hFFFF;
    end else if (m_accept) begin
      m_px = (px > 1248) ? 1248 : px;
      m_py = (py > 992) ? 992 : py;
      m_full = 1'b1;
    end
  endtask

  task automatic probe(input int x, input int y);
    step(x, y, (x < 1280 && y < 1024), 1'b0, 0, 0);
  endtask

  task automatic offer(input int x, input int y, input int px, input int py);
    step(x, y, (x < 1280 && y < 1024), 1'b1, px, py);
  endtask

  task automatic commit_line();
    step(0, 1024, 1'b0, 1'b0, 0, 0);
    step(1, 1024, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic flush();
    repeat (3) step(1300, 1030, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic check_reset_outputs();
    check_val("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    check_val("rst_hsync", 32'(hsync_out), 32'(1'b0));
    check_val("rst_vsync", 32'(vsync_out), 32'(1'b0));
    check_val("rst_tick", 32'(frame_tick), 32'h0);
    check_val("rst_count", 32'(frame_count), 32'h0);
    check_val("rst_ready", 32'(pos_ready), 32'h1);
  endtask

  initial begin
    model_reset();
    #1;
    check_reset_outputs();
    repeat (2) @(negedge vgaClk);
    rst_n = 1'b1;

    // default sprite
    probe(624, 496); probe(623, 496); probe(655, 527); probe(656, 527);
    probe(0, 5); probe(1279, 700); probe(1300, 10); probe(640, 1023);
    flush();

    // mid-frame offer, takes effect only after commit
    offer(10, 300, 100, 200);
    probe(624, 496); probe(100, 200); probe(640, 510);
    commit_line();
    probe(100, 200); probe(131, 231); probe(132, 200); probe(99, 231);
    probe(624, 496);
    flush();

    // held offers across two frames, second stalls until commit
    offer(5, 5, 10, 10);
    offer(6, 5, 20, 20);
    offer(7, 5, 20, 20);
    step(0, 1024, 1'b0, 1'b1, 20, 20);
    for (int i = 0; i < 4 && m_full == 1'b0; i++) step(1, 1024, 1'b0, 1'b1, 20, 20);
    check_val("stall_accept", 32'(m_full), 32'h1);
    probe(9, 10); probe(10, 10); probe(41, 41); probe(51, 51);
    commit_line();
    probe(19, 20); probe(20, 20); probe(51, 51); probe(10, 10);
    flush();

    // clamped position touches right/bottom edge without wrapping
    offer(3, 3, 2000, 4095);
    commit_line();
    probe(1248, 992); probe(1247, 1000); probe(1278, 1022); probe(1279, 1000);
    probe(1, 1000); probe(1260, 991);
    flush();

    // border has priority over sprite
    offer(3, 3, 0, 0);
    commit_line();
    probe(0, 0); probe(1, 1); probe(31, 31); probe(32, 1);
    flush();

    // reset mid-frame discards the pending position
    offer(5, 400, 500, 500);
    probe(100, 500); probe(0, 500); probe(1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    pos_valid = 1'b0;
    repeat (2) @(negedge vgaClk);
    rst_n = 1'b1;
    probe(624, 496); probe(500, 500);
    commit_line();
    probe(624, 496); probe(500, 500);
    flush();

    // frame counter wrap
    force dut.frame_count_reg = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(posedge vgaClk);
    #1;
    release dut.frame_count_reg;
    offer(3, 3, 700, 700);
    commit_line();
    check_val("wrap_count", 32'(frame_count), 32'h0);
    probe(700, 700);
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
